// File: rtl/curve25519_pkg.sv
// ============================================================================
// curve25519_pkg : field constants and FSM encoding shared by point_encode
// Rev 1.0
// ============================================================================
`default_nettype none

package curve25519_pkg;

  localparam int FE_W  = 255;
  localparam int ENC_W = 256;

  localparam logic [FE_W-1:0] P         = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [FE_W-1:0] P_MINUS_2 = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeb;

  // Bit 254 of the exponent is absorbed by starting with acc = Z.
  localparam logic [7:0] EXP_TOP = 8'd253;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CHECK   = 3'd1;
  localparam state_t S_INV_SQ  = 3'd2;
  localparam state_t S_INV_MUL = 3'd3;
  localparam state_t S_MUL_X   = 3'd4;
  localparam state_t S_MUL_Y   = 3'd5;
  localparam state_t S_FREEZE  = 3'd6;
  localparam state_t S_POST    = 3'd7;

endpackage

`default_nettype wire

// File: rtl/point_encode_fe_mul.sv
// ============================================================================
// fe_mul : 255-bit multiplier mod 2^255-19, fixed latency, one op in flight
// Rev 1.0
// ============================================================================
`default_nettype none

module fe_mul
  import curve25519_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FE_W-1:0] a,
  input  logic [FE_W-1:0] b,
  output logic            done,
  output logic [FE_W-1:0] r
);

  localparam int CW = $clog2(MUL_LAT + 1);

  logic [509:0]    w_prod;
  logic [259:0]    w_t1;
  logic [255:0]    w_t2;
  logic [FE_W-1:0] w_red;
  logic [CW-1:0]   r_cnt;
  logic [FE_W-1:0] r_res;

  // Fold with 2^255 == 19 (mod p); the result stays below 2^255, not canonical.
  assign w_prod = {255'd0, a} * {255'd0, b};
  assign w_t1   = {5'd0, w_prod[254:0]} + {5'd0, w_prod[509:255]} * 260'd19;
  assign w_t2   = {1'b0, w_t1[254:0]} + {251'd0, w_t1[259:255]} * 256'd19;
  assign w_red  = w_t2[254:0] + (w_t2[255] ? 255'd19 : 255'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_res <= '0;
    end else if (start) begin
      r_cnt <= CW'(MUL_LAT);
      r_res <= w_red;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign done = (r_cnt == CW'(1));
  assign r    = r_res;

endmodule

`default_nettype wire

// File: rtl/point_encode.sv
// ============================================================================
// point_encode : extended (X,Y,Z) -> 256-bit compressed Ed25519 encoding
// Rev 1.0
// ============================================================================
`default_nettype none

module point_encode
  import curve25519_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter bit FAST_AFFINE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FE_W-1:0]  px,
  input  logic [FE_W-1:0]  py,
  input  logic [FE_W-1:0]  pz,
  output logic [ENC_W-1:0] enc,
  output logic             err,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             req_busy,
  output logic             res_valid,
  input  logic             res_ready
);

  state_t r_state;
  state_t w_next;

  logic [FE_W-1:0]  r_px, r_py, r_pz;
  logic [FE_W-1:0]  r_acc, r_x, r_y;
  logic [7:0]       r_e;
  logic             r_issued;
  logic [ENC_W-1:0] r_enc;
  logic             r_err, r_res_valid, r_busy, r_req_ready;

  logic             w_mul_start, w_mul_done;
  logic [FE_W-1:0]  w_mul_a, w_mul_b, w_mul_r;
  logic             w_z_bad, w_z_one, w_exp_bit, w_last, w_step;
  logic [255:0]     w_x_sub, w_y_sub;
  logic [FE_W-1:0]  w_x_frz, w_y_frz;

  fe_mul #(
    .MUL_LAT (MUL_LAT)
  ) u_fe_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (w_mul_a),
    .b     (w_mul_b),
    .done  (w_mul_done),
    .r     (w_mul_r)
  );

  assign w_z_bad   = (r_pz == '0) || (r_pz == P);
  assign w_z_one   = (r_pz == FE_W'(1));
  assign w_exp_bit = P_MINUS_2[r_e];
  assign w_last    = (r_e == 8'd0);
  // An exponent step follows a squaring on a clear bit, or any Z multiply.
  assign w_step    = w_mul_done &&
                     (((r_state == S_INV_SQ) && !w_exp_bit) || (r_state == S_INV_MUL));

  assign w_x_sub = {1'b0, r_x} - {1'b0, P};
  assign w_y_sub = {1'b0, r_y} - {1'b0, P};
  assign w_x_frz = w_x_sub[255] ? r_x : w_x_sub[254:0];
  assign w_y_frz = w_y_sub[255] ? r_y : w_y_sub[254:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = S_CHECK;
      S_CHECK: begin
        if (w_z_bad)                     w_next = S_POST;
        else if (w_z_one && FAST_AFFINE) w_next = S_FREEZE;
        else                             w_next = S_INV_SQ;
      end
      S_INV_SQ: begin
        if (w_mul_done) begin
          if (w_exp_bit)   w_next = S_INV_MUL;
          else if (w_last) w_next = S_MUL_X;
        end
      end
      S_INV_MUL: if (w_mul_done) w_next = w_last ? S_MUL_X : S_INV_SQ;
      S_MUL_X:   if (w_mul_done) w_next = S_MUL_Y;
      S_MUL_Y:   if (w_mul_done) w_next = S_FREEZE;
      S_FREEZE:  w_next = S_POST;
      S_POST:    if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mul_start = 1'b0;
    w_mul_a     = r_acc;
    w_mul_b     = r_acc;
    case (r_state)
      S_INV_SQ:  w_mul_start = !r_issued;
      S_INV_MUL: begin
        w_mul_start = !r_issued;
        w_mul_b     = r_pz;
      end
      S_MUL_X: begin
        w_mul_start = !r_issued;
        w_mul_a     = r_px;
      end
      S_MUL_Y: begin
        w_mul_start = !r_issued;
        w_mul_a     = r_py;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px        <= '0;
      r_py        <= '0;
      r_pz        <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_e         <= '0;
      r_issued    <= 1'b0;
      r_enc       <= '0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_req_ready <= 1'b0;

      if (w_mul_start)     r_issued <= 1'b1;
      else if (w_mul_done) r_issued <= 1'b0;

      if (w_step && !w_last) r_e <= r_e - 8'd1;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_px        <= px;
            r_py        <= py;
            r_pz        <= pz;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_z_bad) begin
            r_err       <= 1'b1;
            r_enc       <= '0;
            r_res_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_z_one && FAST_AFFINE) begin
            r_x <= r_px;
            r_y <= r_py;
          end else begin
            r_acc <= r_pz;
            r_e   <= EXP_TOP;
          end
        end
        S_INV_SQ, S_INV_MUL: if (w_mul_done) r_acc <= w_mul_r;
        S_MUL_X:             if (w_mul_done) r_x <= w_mul_r;
        S_MUL_Y:             if (w_mul_done) r_y <= w_mul_r;
        S_FREEZE: begin
          r_enc       <= {w_x_frz[0], w_y_frz};
          r_err       <= 1'b0;
          r_res_valid <= 1'b1;
          r_busy      <= 1'b0;
        end
        S_POST: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign enc       = r_enc;
  assign err       = r_err;
  assign res_valid = r_res_valid;
  assign req_busy  = r_busy;
  assign req_ready = r_req_ready;

endmodule

`default_nettype wire

// File: tb/tb_point_encode.sv
// ============================================================================
// tb_point_encode : table vectors, corner sequences and random vs field model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_point_encode;

  localparam int MUL_LAT = 4;
  localparam int LAT_GEN = 3 + 508 * (MUL_LAT + 1);
  localparam int LIMIT   = LAT_GEN + 100;

  localparam logic [254:0] TP = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [254:0] BX = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [254:0] BY = 255'h6666666666666666666666666666666666666666666666666666666666666658;

  logic         clk = 1'b0;
  logic         rst;
  logic [254:0] px, py, pz;
  logic [255:0] enc;
  logic         err, req_valid, req_ready, req_busy, res_valid, res_ready;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string        name;
    logic [254:0] x, y, z;
    logic [255:0] enc;
    logic         err;
    int           lat;
    int           hold;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  point_encode #(
    .MUL_LAT     (MUL_LAT),
    .FAST_AFFINE (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .px        (px),
    .py        (py),
    .pz        (pz),
    .enc       (enc),
    .err       (err),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_busy  (req_busy),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference field arithmetic: plain multiply and modulo.
  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] t;
    t = ({255'd0, a} * {255'd0, b}) % {255'd0, TP};
    return t[254:0];
  endfunction

  function automatic logic [254:0] fpow(input logic [254:0] a, input logic [254:0] e);
    logic [254:0] acc;
    acc = 255'd1;
    for (int i = 254; i >= 0; i--) begin
      acc = fmul(acc, acc);
      if (e[i]) acc = fmul(acc, a);
    end
    return acc;
  endfunction

  function automatic logic [255:0] model_enc(input logic [254:0] x, input logic [254:0] y,
                                             input logic [254:0] z);
    logic [254:0] zi, ax, ay;
    if (z == 255'd0 || z == TP) return 256'd0;
    zi = fpow(z, TP - 255'd2);
    ax = fmul(x, zi);
    ay = fmul(y, zi);
    return {ax[0], ay};
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[254:0];
  endfunction

  task automatic run(input string name, input logic [254:0] x, input logic [254:0] y,
                     input logic [254:0] z, input logic [255:0] exp_enc, input logic exp_err,
                     input int exp_lat, input int hold);
    int           lat, gaps, extra, unstable;
    logic [255:0] enc0;
    logic         err0;
    @(negedge clk);
    px = x; py = y; pz = z; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({name, " req_ready"}, req_ready, 1'b1);
    lat = 1; gaps = 0; extra = 0;
    while (lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      if (res_valid) break;
      if (!req_busy) gaps++;
      if (req_ready) extra++;
      req_valid = (lat % 7 == 0);
    end
    req_valid = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_gaps"}, gaps, 0);
    check({name, " busy_at_res"}, req_busy, 1'b0);
    check({name, " enc"}, enc, exp_enc);
    check({name, " err"}, err, exp_err);
    enc0 = enc; err0 = err; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      if (!res_valid || enc !== enc0 || err !== err0) unstable++;
      if (req_ready) extra++;
    end
    req_valid = 1'b0;
    if (hold > 0) check({name, " hold_stable"}, unstable, 0);
    check({name, " spurious_ready"}, extra, 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, " res_drop"}, res_valid, 1'b0);
  endtask

  initial begin
    logic [254:0] x, y, z;
    logic         e_err;
    int           e_lat;
    int           seen;

    tbl[0] = '{"base_affine", BX, BY, 255'd1, {1'b0, BY}, 1'b0, 3, 50};
    tbl[1] = '{"base_proj", fmul(BX, 255'd2), fmul(BY, 255'd2), 255'd2, {1'b0, BY}, 1'b0, LAT_GEN, 0};
    tbl[2] = '{"base_neg", TP - BX, BY, 255'd1, {1'b1, BY}, 1'b0, 3, 0};
    tbl[3] = '{"identity", 255'd0, 255'd1, 255'd1, 256'd1, 1'b0, 3, 0};
    tbl[4] = '{"noncanon_y", 255'd0, TP + 255'd5, 255'd1, 256'd5, 1'b0, 3, 0};
    tbl[5] = '{"z_zero", BX, BY, 255'd0, 256'd0, 1'b1, 2, 5};
    tbl[6] = '{"z_p", BX, BY, TP, 256'd0, 1'b1, 2, 0};

    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    px = '0; py = '0; pz = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res_valid", res_valid, 1'b0);
    check("reset req_busy", req_busy, 1'b0);
    check("reset req_ready", req_ready, 1'b0);
    check("reset err", err, 1'b0);
    check("reset enc", enc, 256'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].enc, tbl[i].err, tbl[i].lat, tbl[i].hold);

    // Asynchronous reset in the middle of the inversion.
    @(negedge clk);
    px = fmul(BX, 255'd2); py = fmul(BY, 255'd2); pz = 255'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("midrun busy", req_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort req_busy", req_busy, 1'b0);
    check("abort res_valid", res_valid, 1'b0);
    check("abort enc", enc, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (LAT_GEN) begin
      @(posedge clk); #1;
      if (res_valid || req_busy) seen++;
    end
    check("abort no_result", seen, 0);
    run("after_abort", fmul(BX, 255'd3), fmul(BY, 255'd3), 255'd3, {1'b0, BY}, 1'b0, LAT_GEN, 0);

    for (int k = 0; k < 12; k++) begin
      x = rnd255();
      y = rnd255();
      if (k % 3 == 0) y = TP + 255'($urandom_range(0, 18));
      z = (k < 4) ? rnd255() : 255'd1;
      e_err = (z == 255'd0) || (z == TP);
      e_lat = e_err ? 2 : ((z == 255'd1) ? 3 : LAT_GEN);
      run($sformatf("rand%0d", k), x, y, z, model_enc(x, y, z), e_err, e_lat, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
